pixel_serializer: RTL
=====================

PIXEL_SERIALIZER -- requirements
Module: pixel_serializer

Interface
REQ-001 SHALL have parameter COLOR_DEPTH, default 8, bits per color component.
REQ-002 SHALL have parameter CNT_W, default 16, width of pixel_count.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 rgb_in  input  3*COLOR_DEPTH  pixel word {R,G,B}, R in MSBs.
REQ-007 rgb_valid  input  1  rgb_in/rgb_last valid this cycle.
REQ-008 rgb_last  input  1  pixel is the final pixel of its frame.
REQ-009 rgb_ready  output  1  block accepts a pixel this cycle.
REQ-010 pixel_out  output  COLOR_DEPTH  serialized color component.
REQ-011 valid_out  output  1  pixel_out/color_out/last_out are valid.
REQ-012 color_out  output  3  component tag: 0 RED, 1 GREEN, 2 BLUE, 3 VOID.
REQ-013 last_out  output  1  beat belongs to the frame's final pixel.
REQ-014 frame_done  output  1  one-cycle pulse marking the frame end.
REQ-015 pixel_count  output  CNT_W  complete pixels emitted in the current frame.

Function
REQ-016 A pixel SHALL be accepted only on a rising edge where rgb_valid and rgb_ready are both 1; acceptance writes {rgb_in, rgb_last} into a 2-entry FIFO.
REQ-017 rgb_ready SHALL equal (FIFO occupancy < 2), derived from registered occupancy only, with no combinational path from rgb_valid.
REQ-018 FSM states SHALL be IDLE, SEND_R, SEND_G and SEND_B; all outputs SHALL be registered.
REQ-019 Transitions: IDLE->SEND_R when FIFO non-empty; SEND_R->SEND_G; SEND_G->SEND_B; SEND_B->SEND_R if FIFO non-empty, else ->IDLE.
REQ-020 On entering SEND_R, the FIFO head SHALL be popped into a hold register; G and B SHALL come from the hold register.
REQ-021 Latency: a pixel accepted at edge k into an empty, idle block SHALL present R from edge k+1, G from k+2 and B from k+3.
REQ-022 Throughput SHALL be one pixel per 3 cycles, with no idle beat between back-to-back pixels.
REQ-023 In SEND_R/G/B: valid_out=1, color_out=0/1/2 respectively, and pixel_out=hold[R]/hold[G]/hold[B].
REQ-024 In IDLE: valid_out=0, color_out=3 (VOID), pixel_out=0, last_out=0.
REQ-025 last_out SHALL equal the held pixel's last flag on all three beats of that pixel.
REQ-026 pixel_count SHALL increment by 1 on each B beat, saturating at 2^CNT_W-1.
REQ-027 On a B beat with last=1: frame_done=1 for that beat only, and pixel_count SHALL read 0 from the next cycle.
REQ-028 A push with a simultaneous pop SHALL leave occupancy unchanged, and the FIFO SHALL preserve pixel order.
REQ-029 A push SHALL never occur when occupancy is 2 (rgb_ready=0); rgb_valid while rgb_ready=0 SHALL be ignored without corrupting the FIFO.
REQ-030 FIFO pointers SHALL be 1 bit and wrap modulo 2.
REQ-031 rgb_in and rgb_last SHALL be sampled only at acceptance; later changes SHALL not affect a held pixel.

Reset
REQ-032 rst=1 SHALL force state IDLE, FIFO empty, pointers 0, hold register 0, pixel_count=0 and frame_done=0.
REQ-033 During reset, outputs SHALL be valid_out=0, color_out=3, pixel_out=0, last_out=0 and rgb_ready=0, with rgb_ready=1 from the first cycle after rst deasserts.
REQ-034 Reset asserted mid-pixel (SEND_G or SEND_B) SHALL discard the partial pixel and all FIFO contents; no remaining beats SHALL be emitted.

Verification
REQ-035 Single pixel {0x12,0x34,0x56} with last=1, accepted at edge k -> beats (0x12,0), (0x34,1), (0x56,2) at k+1..k+3, each with last_out=1; frame_done=1 at k+3 only; VOID from k+4.
REQ-036 40-pixel frame, rgb_valid held high, last on pixel 40 -> 120 contiguous valid beats in R,G,B order; last_out only on beats 118-120; pixel_count steps 1..39 and then 0; one frame_done pulse.
REQ-037 Backpressure: rgb_valid held high -> occupancy reaches 2 and rgb_ready drops, then rises for one cycle per B-beat pop; no pixel is lost or duplicated; output order matches input order.
REQ-038 Bubbles: valid pattern 1,0,0,0,0,1 -> second pixel's R beat follows VOID cycles; color_out=3 and pixel_out=0 during the gap.
REQ-039 rst pulsed for 1 cycle during SEND_G of pixel 5 of 10 -> next cycle VOID, pixel_count=0, no B beat for pixel 5; a fresh frame then streams correctly.
REQ-040 Two frames of 3 pixels each, back-to-back -> two frame_done pulses 9 cycles apart; pixel_count returns to 0 between frames.

Source files
------------

// File: rtl/pixel_serializer.sv
// Serializes {R,G,B} pixels into three tagged component beats per pixel.
// Input side is a 2-entry FIFO; every output is registered.
module pixel_serializer #(
    parameter int COLOR_DEPTH = 8,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3*COLOR_DEPTH-1:0] rgb_in,
    input  logic                     rgb_valid,
    input  logic                     rgb_last,
    output logic                     rgb_ready,
    output logic [COLOR_DEPTH-1:0]   pixel_out,
    output logic                     valid_out,
    output logic [2:0]               color_out,
    output logic                     last_out,
    output logic                     frame_done,
    output logic [CNT_W-1:0]         pixel_count
);

    localparam int PW = 3*COLOR_DEPTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND_R,
        SEND_G,
        SEND_B
    } state_t;

    state_t state, state_next;

    logic [PW-1:0]          fifo [2];
    logic                   wr_ptr, rd_ptr;
    logic [1:0]             occ, occ_next;
    logic [PW-1:0]          hold, hold_next;
    logic                   push, pop;
    logic [COLOR_DEPTH-1:0] pixel_next;
    logic [2:0]             color_next;
    logic                   valid_next, last_next, done_next;
    logic [CNT_W-1:0]       count_next;

    assign push = rgb_valid && rgb_ready;

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (occ != 2'd0) begin
                    state_next = SEND_R;
                    pop        = 1'b1;
                end
            end
            SEND_R: state_next = SEND_G;
            SEND_G: state_next = SEND_B;
            SEND_B: begin
                if (occ != 2'd0) begin
                    state_next = SEND_R;
                    pop        = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        occ_next = occ;
        if (push && !pop) begin
            occ_next = occ + 2'd1;
        end else if (pop && !push) begin
            occ_next = occ - 2'd1;
        end
        hold_next = pop ? fifo[rd_ptr] : hold;
    end

    // Output registers are loaded from the upcoming state and hold contents,
    // so each beat appears in the same cycle the FSM enters its state.
    always_comb begin
        valid_next = 1'b0;
        color_next = 3'd3;
        pixel_next = '0;
        last_next  = 1'b0;
        done_next  = 1'b0;
        case (state_next)
            SEND_R: begin
                valid_next = 1'b1;
                color_next = 3'd0;
                pixel_next = hold_next[PW-1 -: COLOR_DEPTH];
                last_next  = hold_next[0];
            end
            SEND_G: begin
                valid_next = 1'b1;
                color_next = 3'd1;
                pixel_next = hold_next[PW-1-COLOR_DEPTH -: COLOR_DEPTH];
                last_next  = hold_next[0];
            end
            SEND_B: begin
                valid_next = 1'b1;
                color_next = 3'd2;
                pixel_next = hold_next[COLOR_DEPTH -: COLOR_DEPTH];
                last_next  = hold_next[0];
                done_next  = hold_next[0];
            end
            default: ;
        endcase
    end

    // A pixel counts as complete once its B beat has been presented.
    always_comb begin
        count_next = pixel_count;
        if (state == SEND_B) begin
            if (hold[0]) begin
                count_next = '0;
            end else if (pixel_count != '1) begin
                count_next = pixel_count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= {rgb_in, rgb_last};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            occ         <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            hold        <= '0;
            rgb_ready   <= 1'b0;
            valid_out   <= 1'b0;
            color_out   <= 3'd3;
            pixel_out   <= '0;
            last_out    <= 1'b0;
            frame_done  <= 1'b0;
            pixel_count <= '0;
        end else begin
            state       <= state_next;
            occ         <= occ_next;
            hold        <= hold_next;
            rgb_ready   <= (occ_next != 2'd2);
            valid_out   <= valid_next;
            color_out   <= color_next;
            pixel_out   <= pixel_next;
            last_out    <= last_next;
            frame_done  <= done_next;
            pixel_count <= count_next;
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

endmodule
